pulse_transmitter_sequencer: RTL and testbench
==============================================

PULSE_TRANSMITTER_SEQUENCER -- requirements
Module: pulse_transmitter_sequencer

Interface
REQ-001 SHALL have parameter FIFO_DEPTH, default 4, meaning the number of queued symbols (power of two, 2..16).
REQ-002 SHALL have port clk, input, 1, meaning the single clock; all logic is on its rising edge.
REQ-003 SHALL have port sys_rst, input, 1, meaning the reset; reset is synchronous and active-high.
REQ-004 SHALL have port wr_valid, input, 1, meaning a symbol write request.
REQ-005 SHALL have port wr_data, input, 9, meaning {level, duration[7:0]}.
REQ-006 SHALL have port wr_ready, output, 1, meaning the FIFO is not full.
REQ-007 SHALL have port start, input, 1, meaning a one-cycle request to begin transmission.
REQ-008 SHALL have port stop, input, 1, meaning a one-cycle abort request.
REQ-009 SHALL have port prescale, input, 4, meaning the tick divider; one tick = prescale+1 clocks.
REQ-010 SHALL have port idle_level, input, 1, meaning the pulse_out value while idle.
REQ-011 SHALL have port pulse_out, output, 1, meaning the registered transmit pin.
REQ-012 SHALL have port busy, output, 1, meaning the block is in EMIT.
REQ-013 SHALL have port done, output, 1, meaning a one-cycle pulse on natural completion.
REQ-014 SHALL have port fifo_level, output, $clog2(FIFO_DEPTH)+1, meaning the number of occupied entries.

Function
REQ-015 SHALL accept a write iff wr_valid && wr_ready; wr_ready = (fifo_level != FIFO_DEPTH), derived from registered count only.
REQ-016 SHALL implement states IDLE and EMIT; in IDLE, pulse_out = idle_level and busy = 0.
REQ-017 SHALL, on start in IDLE with fifo_level > 0, pop the head and enter EMIT; pulse_out shows the head level on the next cycle.
REQ-018 SHALL ignore start in IDLE when the FIFO is empty, and ignore start in EMIT.
REQ-019 SHALL hold each symbol for exactly (duration+1)*(prescale+1) clocks; duration 0 gives 1 tick.
REQ-020 SHALL sample prescale only at each symbol load; changes mid-symbol apply from the next symbol.
REQ-021 SHALL, on the last clock of a symbol with the FIFO non-empty, pop the next symbol with no gap cycle.
REQ-022 SHALL, on the last clock of a symbol with the FIFO empty, go to IDLE, pulse done for 1 cycle, and drive idle_level from the next cycle.
REQ-023 SHALL, on stop in EMIT, go to IDLE the next cycle, flush the FIFO (fifo_level = 0), and not assert done.
REQ-024 SHALL give stop priority when start and stop coincide; stop in IDLE flushes the FIFO.
REQ-025 SHALL allow a write and a pop in the same cycle, with fifo_level unchanged; a write coincident with a stop flush is discarded.
REQ-026 SHALL wrap read and write pointers modulo FIFO_DEPTH.

Reset
REQ-027 SHALL, while sys_rst is high, set state IDLE, FIFO empty, counters 0, pulse_out 0, busy 0, done 0.
REQ-028 SHALL, when reset is asserted mid-EMIT, abort the symbol without asserting done; pulse_out = idle_level from the first cycle after reset releases.

Configuration
REQ-029 SHALL, with macro PULSE_TX_CARRIER_EN defined, add input carrier_half [7:0]; while the symbol level is 1, pulse_out toggles every carrier_half+1 clocks, starting high at each symbol load with the carrier counter cleared; level 0 symbols drive 0.
REQ-030 SHALL, without PULSE_TX_CARRIER_EN, omit carrier_half and drive pulse_out directly from the symbol level.

Verification
REQ-031 SHALL cover: prescale=0, write {1,3},{0,1}, start -> pulse_out high 4 clks, low 2 clks, then idle_level, with done for 1 clk.
REQ-032 SHALL cover: write 5 symbols with FIFO_DEPTH=4 -> the 5th is refused (wr_ready=0) and fifo_level=4.
REQ-033 SHALL cover: prescale=2, symbol {1,0} -> high for 3 clks; prescale changed to 0 mid-symbol takes effect only on the next symbol.
REQ-034 SHALL cover: stop on the 2nd clk of a 10-clk symbol -> pulse_out = idle_level next clk, fifo_level=0, no done.
REQ-035 SHALL cover: start and stop in the same cycle with 2 queued symbols -> stays IDLE and the FIFO is flushed.
REQ-036 SHALL cover: PULSE_TX_CARRIER_EN, carrier_half=1, symbol {1,7} -> pulse_out pattern 1,1,0,0,1,1,0,0.

Source files
------------

// File: rtl/pulse_transmitter_sequencer.sv
// Symbol FIFO feeding a timed pulse emitter: each {level, duration} symbol is held for
// (duration+1)*(prescale+1) clocks. Optional carrier modulation under PULSE_TX_CARRIER_EN.
module pulse_transmitter_sequencer #(
    parameter int FIFO_DEPTH = 4
) (
    input  logic                          clk,
    input  logic                          sys_rst,
    input  logic                          wr_valid,
    input  logic [8:0]                    wr_data,
    output logic                          wr_ready,
    input  logic                          start,
    input  logic                          stop,
    input  logic [3:0]                    prescale,
    input  logic                          idle_level,
`ifdef PULSE_TX_CARRIER_EN
    input  logic [7:0]                    carrier_half,
`endif
    output logic                          pulse_out,
    output logic                          busy,
    output logic                          done,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] FULL = CW'(FIFO_DEPTH);

    typedef enum logic [0:0] {IDLE, EMIT} state_t;

    state_t          state_q, state_d;
    logic [8:0]      mem [FIFO_DEPTH];
    logic [AW-1:0]   rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
    logic [CW-1:0]   count_q, count_d;
    logic            lvl_q, lvl_d;
    logic [7:0]      dur_q, dur_d, tcnt_q, tcnt_d;
    logic [3:0]      pre_q, pre_d, pcnt_q, pcnt_d;
    logic            pulse_q, pulse_d, done_q, done_d;
`ifdef PULSE_TX_CARRIER_EN
    logic [7:0]      ccnt_q, ccnt_d;
`endif

    logic            push, pop, load, fifo_empty, tick_end, sym_end;
    logic [8:0]      head;

    assign wr_ready   = (count_q != FULL);
    assign fifo_level = count_q;
    assign busy       = (state_q == EMIT);
    assign pulse_out  = pulse_q;
    assign done       = done_q;

    always_comb begin
        state_d    = state_q;
        rd_ptr_d   = rd_ptr_q;
        wr_ptr_d   = wr_ptr_q;
        count_d    = count_q;
        lvl_d      = lvl_q;
        dur_d      = dur_q;
        pre_d      = pre_q;
        pcnt_d     = pcnt_q;
        tcnt_d     = tcnt_q;
        pulse_d    = pulse_q;
        done_d     = 1'b0;
`ifdef PULSE_TX_CARRIER_EN
        ccnt_d     = ccnt_q;
`endif
        fifo_empty = (count_q == '0);
        head       = mem[rd_ptr_q];
        tick_end   = (pcnt_q == pre_q);
        sym_end    = tick_end && (tcnt_q == dur_q);
        push       = wr_valid && wr_ready && !stop;
        pop        = 1'b0;
        load       = 1'b0;

        if (stop) begin
            // Abort wins over everything, including a coincident write.
            state_d  = IDLE;
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            count_d  = '0;
            pulse_d  = idle_level;
        end else begin
            case (state_q)
                IDLE: begin
                    pulse_d = idle_level;
                    if (start && !fifo_empty) begin
                        load    = 1'b1;
                        state_d = EMIT;
                    end
                end
                EMIT: begin
                    if (sym_end) begin
                        if (!fifo_empty) begin
                            load = 1'b1;
                        end else begin
                            state_d = IDLE;
                            done_d  = 1'b1;
                            pulse_d = idle_level;
                        end
                    end else begin
                        if (tick_end) begin
                            pcnt_d = '0;
                            tcnt_d = tcnt_q + 8'd1;
                        end else begin
                            pcnt_d = pcnt_q + 4'd1;
                        end
`ifdef PULSE_TX_CARRIER_EN
                        if (lvl_q) begin
                            if (ccnt_q == carrier_half) begin
                                ccnt_d  = '0;
                                pulse_d = ~pulse_q;
                            end else begin
                                ccnt_d = ccnt_q + 8'd1;
                            end
                        end else begin
                            pulse_d = 1'b0;
                        end
`else
                        pulse_d = lvl_q;
`endif
                    end
                end
                default: state_d = IDLE;
            endcase
        end

        // Symbol load: prescale is captured here so mid-symbol changes wait for the next one.
        if (load) begin
            pop     = 1'b1;
            lvl_d   = head[8];
            dur_d   = head[7:0];
            pre_d   = prescale;
            pcnt_d  = '0;
            tcnt_d  = '0;
            pulse_d = head[8];
`ifdef PULSE_TX_CARRIER_EN
            ccnt_d  = '0;
`endif
        end

        if (!stop) begin
            if (push) wr_ptr_d = wr_ptr_q + AW'(1);
            if (pop)  rd_ptr_d = rd_ptr_q + AW'(1);
            count_d = count_q + CW'(push) - CW'(pop);
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr_q] <= wr_data;
    end

    always_ff @(posedge clk) begin
        if (sys_rst) begin
            state_q  <= IDLE;
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
            lvl_q    <= 1'b0;
            dur_q    <= '0;
            pre_q    <= '0;
            pcnt_q   <= '0;
            tcnt_q   <= '0;
            pulse_q  <= 1'b0;
            done_q   <= 1'b0;
`ifdef PULSE_TX_CARRIER_EN
            ccnt_q   <= '0;
`endif
        end else begin
            state_q  <= state_d;
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
            lvl_q    <= lvl_d;
            dur_q    <= dur_d;
            pre_q    <= pre_d;
            pcnt_q   <= pcnt_d;
            tcnt_q   <= tcnt_d;
            pulse_q  <= pulse_d;
            done_q   <= done_d;
`ifdef PULSE_TX_CARRIER_EN
            ccnt_q   <= ccnt_d;
`endif
        end
    end
endmodule

// File: tb/tb_pulse_transmitter_sequencer.sv
// Scoreboard bench for pulse_transmitter_sequencer: stimulus queues per-cycle expectations,
// a negedge monitor retires them against the DUT outputs.
module tb_pulse_transmitter_sequencer;
    localparam int DEPTH = 4;

    logic       clk = 1'b0;
    logic       sys_rst, wr_valid, wr_ready, start, stop, idle_level;
    logic [8:0] wr_data;
    logic [3:0] prescale;
    logic       pulse_out, busy, done;
    logic [2:0] fifo_level;
`ifdef PULSE_TX_CARRIER_EN
    logic [7:0] carrier_half;
`endif

    pulse_transmitter_sequencer #(.FIFO_DEPTH(DEPTH)) dut (
        .clk(clk), .sys_rst(sys_rst), .wr_valid(wr_valid), .wr_data(wr_data),
        .wr_ready(wr_ready), .start(start), .stop(stop), .prescale(prescale),
        .idle_level(idle_level),
`ifdef PULSE_TX_CARRIER_EN
        .carrier_half(carrier_half),
`endif
        .pulse_out(pulse_out), .busy(busy), .done(done), .fifo_level(fifo_level)
    );

    always #5 clk = ~clk;

    typedef struct {
        int cyc; int p; int b; int d; int lv; int rd; int tag;
    } exp_t;

    exp_t q[$];
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;
    int   tid = 0;

    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: retire every expectation due this cycle; -1 fields are don't-care.
    always @(negedge clk) begin
        int i;
        exp_t e;
        i = 0;
        while (i < q.size()) begin
            if (q[i].cyc < cyc) begin
                e = q[i];
                checks++; errors++;
                $display("FAIL t%0d missed check due at cycle %0d (now %0d)", e.tag, e.cyc, cyc);
                q.delete(i);
            end else if (q[i].cyc == cyc) begin
                e = q[i];
                if (e.p >= 0) begin
                    checks++;
                    if (pulse_out !== 1'(e.p)) begin
                        errors++;
                        $display("FAIL t%0d@%0d pulse_out got %b exp %0d", e.tag, cyc, pulse_out, e.p);
                    end
                end
                if (e.b >= 0) begin
                    checks++;
                    if (busy !== 1'(e.b)) begin
                        errors++;
                        $display("FAIL t%0d@%0d busy got %b exp %0d", e.tag, cyc, busy, e.b);
                    end
                end
                if (e.d >= 0) begin
                    checks++;
                    if (done !== 1'(e.d)) begin
                        errors++;
                        $display("FAIL t%0d@%0d done got %b exp %0d", e.tag, cyc, done, e.d);
                    end
                end
                if (e.lv >= 0) begin
                    checks++;
                    if (fifo_level !== 3'(e.lv)) begin
                        errors++;
                        $display("FAIL t%0d@%0d fifo_level got %0d exp %0d", e.tag, cyc, fifo_level, e.lv);
                    end
                end
                if (e.rd >= 0) begin
                    checks++;
                    if (wr_ready !== 1'(e.rd)) begin
                        errors++;
                        $display("FAIL t%0d@%0d wr_ready got %b exp %0d", e.tag, cyc, wr_ready, e.rd);
                    end
                end
                q.delete(i);
            end else begin
                i++;
            end
        end
    end

    task automatic ex(input int off, input int p, input int b, input int d, input int lv, input int rd);
        exp_t e;
        e = '{cyc + off, p, b, d, lv, rd, tid};
        q.push_back(e);
    endtask

    task automatic tk(input int n);
        repeat (n) @(negedge clk);
    endtask

    // One-cycle write; explv is the occupancy expected right after it.
    task automatic wr(input logic l, input int dur, input int explv);
        wr_valid = 1'b1;
        wr_data  = {l, 8'(dur)};
        ex(1, -1, -1, -1, explv, (explv < DEPTH) ? 1 : 0);
        tk(1);
    endtask

    initial begin
        sys_rst = 1'b1; wr_valid = 1'b0; wr_data = '0; start = 1'b0; stop = 1'b0;
        prescale = 4'd0; idle_level = 1'b1;
`ifdef PULSE_TX_CARRIER_EN
        carrier_half = 8'hFF;
`endif
        @(negedge clk);

        // Reset state, then idle_level after release
        tid = 0;
        ex(1, 0, 0, 0, 0, 1); ex(2, 0, 0, 0, 0, 1);
        tk(2);
        sys_rst = 1'b0;
        ex(1, 1, 0, 0, 0, 1);
        tk(2);

        // {1,3},{0,1}: high 4, low 2, idle + done
        tid = 1; idle_level = 1'b1; prescale = 4'd0;
        wr(1'b1, 3, 1); wr(1'b0, 1, 2); wr_valid = 1'b0;
        start = 1'b1;
        ex(1, 1, 1, 0, 1, 1); ex(2, 1, 1, 0, -1, -1); ex(3, 1, 1, 0, -1, -1); ex(4, 1, 1, 0, -1, -1);
        ex(5, 0, 1, 0, 0, 1); ex(6, 0, 1, 0, -1, -1); ex(7, 1, 0, 1, 0, 1); ex(8, 1, 0, 0, -1, -1);
        tk(1); start = 1'b0; tk(8);

        // Five writes into depth 4: fifth refused and never emitted
        tid = 2; idle_level = 1'b0;
        wr(1'b1, 0, 1); wr(1'b0, 0, 2); wr(1'b1, 1, 3); wr(1'b0, 0, 4); wr(1'b1, 5, 4);
        wr_valid = 1'b0;
        start = 1'b1;
        ex(1, 1, 1, 0, 3, 1); ex(2, 0, 1, 0, 2, 1); ex(3, 1, 1, 0, 1, 1); ex(4, 1, 1, 0, 1, 1);
        ex(5, 0, 1, 0, 0, 1); ex(6, 0, 0, 1, 0, 1); ex(7, 0, 0, 0, 0, 1);
        tk(1); start = 1'b0; tk(7);

        // prescale=2 latched at load; change to 0 mid-symbol applies to next symbol
        tid = 3; idle_level = 1'b1;
        wr(1'b1, 0, 1); wr(1'b0, 1, 2); wr_valid = 1'b0;
        prescale = 4'd2; start = 1'b1;
        ex(1, 1, 1, 0, 1, 1); ex(2, 1, 1, 0, -1, -1); ex(3, 1, 1, 0, -1, -1);
        ex(4, 0, 1, 0, 0, 1); ex(5, 0, 1, 0, -1, -1); ex(6, 1, 0, 1, 0, 1);
        tk(1); start = 1'b0; prescale = 4'd0; tk(7);

        // stop on 2nd clk of a 10-clk symbol; coincident write discarded; start on empty ignored
        tid = 4; idle_level = 1'b0;
        wr(1'b1, 9, 1); wr(1'b0, 3, 2); wr_valid = 1'b0;
        start = 1'b1;
        ex(1, 1, 1, 0, 1, 1);
        tk(1); start = 1'b0;
        ex(1, 1, 1, 0, -1, -1);
        tk(1);
        stop = 1'b1; wr_valid = 1'b1; wr_data = {1'b1, 8'd2};
        ex(1, 0, 0, 0, 0, 1); ex(2, 0, 0, 0, 0, 1); ex(3, 0, 0, 0, -1, -1);
        tk(1); stop = 1'b0; wr_valid = 1'b0; tk(1);
        start = 1'b1;
        ex(1, 0, 0, 0, 0, 1); ex(2, 0, 0, 0, 0, 1);
        tk(1); start = 1'b0; tk(3);

        // start and stop together with two queued: stays idle, flushed
        tid = 5; idle_level = 1'b1;
        wr(1'b1, 2, 1); wr(1'b0, 2, 2); wr_valid = 1'b0;
        start = 1'b1; stop = 1'b1;
        ex(1, 1, 0, 0, 0, 1); ex(2, 1, 0, 0, 0, 1); ex(3, 1, 0, 0, 0, 1);
        tk(1); start = 1'b0; stop = 1'b0; tk(3);

        // write coincident with a pop keeps level; start during EMIT has no effect
        tid = 6; idle_level = 1'b0;
        wr(1'b1, 0, 1); wr(1'b0, 2, 2); wr_valid = 1'b0;
        start = 1'b1;
        ex(1, 1, 1, 0, 1, 1);
        tk(1);
        wr_valid = 1'b1; wr_data = {1'b1, 8'd0};
        ex(1, 0, 1, 0, 1, 1); ex(2, 0, 1, 0, -1, -1); ex(3, 0, 1, 0, -1, -1);
        ex(4, 1, 1, 0, 0, 1); ex(5, 0, 0, 1, 0, 1);
        tk(1); wr_valid = 1'b0; start = 1'b0; tk(6);

        // reset mid-EMIT: no done, idle_level right after release
        tid = 7; idle_level = 1'b1;
        wr(1'b0, 9, 1); wr_valid = 1'b0;
        start = 1'b1;
        ex(1, 0, 1, 0, 0, 1);
        tk(1); start = 1'b0; tk(1);
        sys_rst = 1'b1;
        ex(1, 0, 0, 0, 0, 1);
        tk(1); sys_rst = 1'b0;
        ex(1, 1, 0, 0, 0, 1); ex(2, 1, 0, 0, 0, 1);
        tk(4);

`ifdef PULSE_TX_CARRIER_EN
        // carrier_half=1, {1,7}: 1,1,0,0,1,1,0,0
        tid = 8; idle_level = 1'b0; carrier_half = 8'd1;
        wr(1'b1, 7, 1); wr_valid = 1'b0;
        start = 1'b1;
        ex(1, 1, 1, 0, 0, 1); ex(2, 1, 1, 0, -1, -1); ex(3, 0, 1, 0, -1, -1); ex(4, 0, 1, 0, -1, -1);
        ex(5, 1, 1, 0, -1, -1); ex(6, 1, 1, 0, -1, -1); ex(7, 0, 1, 0, -1, -1); ex(8, 0, 1, 0, -1, -1);
        ex(9, 0, 0, 1, 0, 1);
        tk(1); start = 1'b0; tk(10);
`endif

        for (int n = 0; n < 100 && q.size() > 0; n++) tk(1);
        while (q.size() > 0) begin
            checks++; errors++;
            $display("FAIL t%0d expectation for cycle %0d never retired", q[0].tag, q[0].cyc);
            void'(q.pop_front());
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
